// File: rtl/mux_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux_share_arbiter_pkg : state encoding and default width for the arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mux_share_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t OWN0 = 2'd1;
  localparam state_t OWN1 = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mux_share_arbiter_mux.sv
// ---------------------------------------------------------------------------
// mux_share_arbiter_mux : plain 2:1 WIDTH-bit multiplexer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux_share_arbiter_mux #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = sel_i ? in1_i : in0_i;

endmodule

`default_nettype wire

// File: rtl/mux_share_arbiter.sv
// ---------------------------------------------------------------------------
// mux_share_arbiter : round-robin owner of a shared 2:1 datapath, bounded hold
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux_share_arbiter
  import mux_share_arbiter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             done,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  localparam int                HOLD_W    = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              ptr_q, ptr_d;
  logic              sel_q, sel_d;
  logic              gnt0_q, gnt1_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      ptr_q   <= 1'b1;
      sel_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt0_q  <= (state_d == OWN0);
      gnt1_q  <= (state_d == OWN1);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = ptr_q ? OWN0 : OWN1;
        else if (req0)     state_d = OWN0;
        else if (req1)     state_d = OWN1;
      end
      OWN0: begin
        if (done || !req0 || (hold_q == HOLD_LAST && req1))
          state_d = req1 ? OWN1 : IDLE;
      end
      OWN1: begin
        if (done || !req1 || (hold_q == HOLD_LAST && req0))
          state_d = req0 ? OWN0 : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Counter restarts on every ownership change; saturation keeps an
    // uncontested owner in place until the other side shows up.
    hold_d = hold_q;
    if (state_d != state_q || state_d == IDLE)
      hold_d = '0;
    else if (hold_q != HOLD_LAST)
      hold_d = hold_q + 1'b1;

    ptr_d = ptr_q;
    sel_d = sel_q;
    if (state_d != state_q) begin
      if (state_d == OWN0) begin
        ptr_d = 1'b0;
        sel_d = 1'b0;
      end else if (state_d == OWN1) begin
        ptr_d = 1'b1;
        sel_d = 1'b1;
      end
    end
  end

  // Output logic
  always_comb begin
    gnt0      = gnt0_q;
    gnt1      = gnt1_q;
    sel       = sel_q;
    out_valid = (gnt0_q & req0) | (gnt1_q & req1);
  end

  mux_share_arbiter_mux #(
    .WIDTH (WIDTH)
  ) u_mux (
    .in0_i (data0),
    .in1_i (data1),
    .sel_i (sel_q),
    .out_o (out_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_mux_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_share_arbiter : directed scenarios plus random traffic, scoreboarded
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mux_share_arbiter;

  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, done = 1'b0;
  logic [31:0] data0 = '0, data1 = '0;
  logic        gnt0, gnt1, sel, out_valid;
  logic [31:0] out_data;

  mux_share_arbiter #(.WIDTH(32), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .done      (done),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        g0;
    logic        g1;
    logic        s;
    logic        v;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: owner (-1 = nobody), last side served, mux side,
  // and how many cycles the current owner has already held the grant.
  int owner = -1;
  int last  = 1;
  int msel  = 0;
  int age   = 0;

  task automatic model_step(input bit rn, input bit q0, input bit q1, input bit dn);
    int nxt;
    bit mine, other;
    if (!rn) begin
      owner = -1; last = 1; msel = 0; age = 0;
      return;
    end
    nxt = owner;
    if (owner < 0) begin
      if (q0 && q1)  nxt = 1 - last;
      else if (q0)   nxt = 0;
      else if (q1)   nxt = 1;
    end else begin
      mine  = (owner == 0) ? q0 : q1;
      other = (owner == 0) ? q1 : q0;
      if (dn || !mine || (other && age >= MAX_HOLD - 1))
        nxt = other ? 1 - owner : -1;
    end
    if (nxt != owner) begin
      age = 0;
      if (nxt >= 0) begin
        last = nxt;
        msel = nxt;
      end
    end else if (owner >= 0) begin
      age++;
    end
    owner = nxt;
  endtask

  // One cycle: drive inputs after the edge, record what the outputs must be
  // during this cycle, then advance the model across the coming edge.
  task automatic cyc(input bit rn, input bit q0, input bit q1, input bit dn,
                     input logic [31:0] d0, input logic [31:0] d1);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; req0 = q0; req1 = q1; done = dn; data0 = d0; data1 = d1;
    e.g0 = (owner == 0);
    e.g1 = (owner == 1);
    e.s  = (msel == 1);
    e.d  = (msel == 1) ? d1 : d0;
    e.v  = (owner == 0 && q0) || (owner == 1 && q1);
    exp_q.push_back(e);
    model_step(rn, q0, q1, dn);
  endtask

  // Monitor: compares mid-cycle, away from the rising edge
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (gnt0 !== e.g0 || gnt1 !== e.g1 || sel !== e.s ||
          out_valid !== e.v || out_data !== e.d) begin
        miscompares++;
        $display("FAIL cycle%0d: gnt0/gnt1/sel/valid/data got %b%b %b %b %h want %b%b %b %b %h",
                 vectors, gnt0, gnt1, sel, out_valid, out_data,
                 e.g0, e.g1, e.s, e.v, e.d);
      end
    end
  end

  initial begin
    logic [31:0] r0, r1;
    bit q0, q1;

    // Reset with both requesting, then release: req0 takes the first tie
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    @(posedge clk);
    cyc(0, 1, 1, 0, 32'h1111_0000, 32'h2222_0000);
    cyc(0, 1, 1, 0, 32'h1111_0001, 32'h2222_0001);
    cyc(1, 1, 1, 0, 32'h1111_0002, 32'h2222_0002);
    cyc(1, 1, 1, 0, 32'h1111_0003, 32'h2222_0003);
    cyc(1, 0, 0, 0, 32'h0, 32'h0);
    cyc(1, 0, 0, 0, 32'h0, 32'h0);

    // Single requester 1, then done back to idle with sel held
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 32'h5555_0000 + i, 32'hABCD);
    cyc(1, 0, 1, 1, 32'h5555_0004, 32'hABCD);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 32'h6666_0000 + i, 32'h7777_0000 + i);

    // Tie alternation, done every third cycle
    for (int i = 0; i < 15; i++) cyc(1, 1, 1, (i % 3) == 2, 32'hA0 + i, 32'hB0 + i);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // Preemption: req1 raised in req0's first granted cycle
    cyc(1, 1, 0, 0, 32'hC0, 32'hD0);
    for (int i = 0; i < 14; i++) cyc(1, 1, 1, 0, 32'hC1 + i, 32'hD1 + i);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // Uncontested saturation then late contender
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, 32'hE000 + i, 32'hF000 + i);
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 32'hE100 + i, 32'hF100 + i);
    cyc(1, 0, 0, 0, 0, 0);

    // Mid-operation reset while req1 owns
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 32'h10 + i, 32'h20 + i);
    cyc(0, 1, 1, 0, 32'h13, 32'h23);
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 32'h14 + i, 32'h24 + i);

    // Random traffic with sticky requests
    q0 = 0; q1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) q0 = ~q0;
      if ($urandom_range(0, 5) == 0) q1 = ~q1;
      r0 = $urandom;
      r1 = $urandom;
      cyc($urandom_range(0, 60) != 0, q0, q1, $urandom_range(0, 7) == 0, r0, r1);
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: pending %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_share_arbiter.md
# mux_share_arbiter

Round-robin arbiter that shares one 32-bit datapath resource (2:1 mux feeding a single downstream port, e.g. one memory port shared by fetch and data access) between two requesters. It runs a req/gnt handshake per requester, drives the mux select from the current owner and bounds ownership with a hold counter so neither side starves. It sits between the two requesting units and the shared port, and is the only driver of the select line.

## Interface

- WIDTH, 32, data width of both inputs and the shared output
- MAX_HOLD, 8, maximum cycles an owner keeps the grant while the other side is requesting (>= 2)

- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous reset, active low, sampled on rising edge of clk
- req0  input  1  requester 0 wants the resource; held high for whole transaction
- req1  input  1  requester 1 wants the resource
- data0  input  WIDTH  requester 0 payload
- data1  input  WIDTH  requester 1 payload
- done  input  1  shared resource finished current transaction (one-cycle pulse)
- gnt0  output  1  requester 0 owns the resource
- gnt1  output  1  requester 1 owns the resource
- sel  output  1  mux select: 0 -> data0, 1 -> data1
- out_data  output  WIDTH  selected payload to the shared port
- out_valid  output  1  owner is granted and still requesting

## Operation

- FSM states: IDLE, OWN0, OWN1; gnt0 = (state==OWN0), gnt1 = (state==OWN1), both registered.
- Reset values: state IDLE, gnt0=gnt1=0, sel=0, hold counter 0, last-served pointer 1 (so req0 wins the first tie), out_valid=0; out_data = data0 while sel=0.
- IDLE: req0 only -> OWN0; req1 only -> OWN1; both -> side opposite to last-served pointer; none -> stay.
- OWNx release condition: done=1, or reqx=0, or (hold==MAX_HOLD-1 and other req=1).
- On release: other req=1 -> go directly to OWNy (no idle bubble); else -> IDLE. Otherwise stay.
- Last-served pointer updates to x on every entry into OWNx.
- sel updates with the grant (sel=1 in OWN1, 0 in OWN0) and holds its last value in IDLE.
- out_data = sel ? data1 : data0, combinational; out_valid = (gnt0 & req0) | (gnt1 & req1).
- Hold counter: cleared on any grant change or entry into IDLE; +1 per cycle in OWNx, saturating at MAX_HOLD-1. Uncontested owner at saturation keeps the grant until the other side requests; preemption then occurs at the next edge.
- done in IDLE ignored. done and reqx drop in the same cycle count as one release.
- rst_n=0 at any edge, mid-transaction included: return to reset values on that edge, no partial release.

## Timing

- Request-to-grant latency from IDLE: 1 cycle (req sampled at edge N, gnt high from cycle N+1).
- Handover: release at edge N -> old gnt low and new gnt high together from cycle N+1; gnt0 and gnt1 never both high.
- Contested owner holds at most MAX_HOLD cycles.
- out_data / out_valid follow sel and req combinationally within the same cycle; no added pipeline stage.

## Structure

- Shared package: state encoding constants (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and default WIDTH.
- One sub-module: the team's existing 2:1 WIDTH-bit `mux`, instantiated for out_data with sel from the FSM; FSM, pointer and hold counter stay in the top.

## Test plan

- Reset: rst_n=0 two cycles with req0=req1=1 -> gnt0=gnt1=0, sel=0, out_valid=0; release reset -> gnt0=1 on the following cycle.
- Single requester: req1=1, data1=32'hABCD -> gnt1=1 one cycle later, sel=1, out_data=32'hABCD; done pulse -> IDLE next cycle, sel stays 1.
- Tie alternation: req0=req1=1 with done every 3 cycles -> grants alternate OWN0, OWN1, OWN0 with no IDLE cycles between.
- Preemption: MAX_HOLD=8, req0 held, req1 raised in its first granted cycle, no done -> gnt0 high exactly 8 cycles, then gnt1.
- Uncontested saturation: req0 alone 20 cycles -> gnt0 stays high; raise req1 -> gnt1 high the cycle after next edge.
- Mid-operation reset: rst_n=0 during OWN1 -> all outputs at reset values after that edge; both req high after release -> gnt0 wins.
